// File: rtl/rx_ctrl_pkg.sv
// Shared defaults and state encoding for the UART receive sequencer.
// The FSM states are the bit-period phases of a frame.
package rx_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam bit DEF_PARITY_EN  = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_frame_status.sv
// Holds one completed frame's status for the consumer.
// Flags overrun when a new frame lands on an unaccepted one.
module rx_frame_status
    import rx_ctrl_pkg::*;
#(
    parameter bit PARITY_EN = DEF_PARITY_EN
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic complete_i,
    input  logic parityErr_i,
    input  logic stopErr_i,
    input  logic frameReady_i,
    input  logic overrunClr_i,
    output logic frameValid_o,
    output logic frameParityErr_o,
    output logic frameStopErr_o,
    output logic overrun_o
);

    logic valid_q, valid_d;
    logic parErr_q, parErr_d;
    logic stopErr_q, stopErr_d;
    logic overrun_q, overrun_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            parErr_q  <= 1'b0;
            stopErr_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            parErr_q  <= parErr_d;
            stopErr_q <= stopErr_d;
            overrun_q <= overrun_d;
        end
    end

    // A completion always wins the slot; an accept only frees it when nothing new arrives.
    always_comb begin
        valid_d   = valid_q;
        parErr_d  = parErr_q;
        stopErr_d = stopErr_q;
        overrun_d = overrun_q;
        if (complete_i) begin
            valid_d   = 1'b1;
            parErr_d  = PARITY_EN ? parityErr_i : 1'b0;
            stopErr_d = stopErr_i;
        end else if (valid_q && frameReady_i) begin
            valid_d = 1'b0;
        end
        if (complete_i && valid_q && !frameReady_i) begin
            overrun_d = 1'b1;
        end else if (overrunClr_i) begin
            overrun_d = 1'b0;
        end
    end

    assign frameValid_o     = valid_q;
    assign frameParityErr_o = parErr_q;
    assign frameStopErr_o   = stopErr_q;
    assign overrun_o        = overrun_q;

endmodule

// File: rtl/rx_ctrl.sv
// UART RX sequencer: times bits from the oversampling tick, validates the
// start bit and strobes the SIPO, parity checker and stop-bit logic.
module rx_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter bit PARITY_EN  = DEF_PARITY_EN
) (
    input  logic rx_clk,
    input  logic rx_rst,
    input  logic sample_tick,
    input  logic rx_in,
    input  logic parity_bit_error,
    output logic shift,
    output logic parity_load,
    output logic check_stop,
    output logic rx_busy,
    output logic frame_valid,
    input  logic frame_ready,
    output logic frame_parity_err,
    output logic frame_stop_err,
    output logic false_start,
    output logic overrun,
    input  logic overrun_clr
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] bitIdx_q, bitIdx_d;
    logic             parErr_q, parErr_d;
    logic             halfEnd;
    logic             bitEnd;

    assign halfEnd = sample_tick && (cnt_q == HALF_LAST);
    assign bitEnd  = sample_tick && (cnt_q == BIT_LAST);

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q  <= RX_IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            parErr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            parErr_q <= parErr_d;
        end
    end

    // Each sampling state counts ticks to the middle of its bit, then acts once.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        parErr_d = parErr_q;
        case (state_q)
            RX_IDLE: begin
                if (sample_tick && !rx_in) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (halfEnd) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    state_d  = rx_in ? RX_IDLE : RX_DATA;
                end else if (sample_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (bitEnd) begin
                    cnt_d    = '0;
                    bitIdx_d = bitIdx_q + IDX_W'(1);
                    if (bitIdx_q == IDX_LAST) begin
                        state_d = PARITY_EN ? RX_PARITY : RX_STOP;
                    end
                end else if (sample_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_PARITY: begin
                if (bitEnd) begin
                    cnt_d    = '0;
                    parErr_d = parity_bit_error;
                    state_d  = RX_STOP;
                end else if (sample_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (bitEnd) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end else if (sample_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are suppressed under reset so an abandoned frame leaves no trace downstream.
    always_comb begin
        shift       = 1'b0;
        parity_load = 1'b0;
        check_stop  = 1'b0;
        false_start = 1'b0;
        rx_busy     = (state_q != RX_IDLE);
        if (!rx_rst) begin
            case (state_q)
                RX_START:  false_start = halfEnd && rx_in;
                RX_DATA:   shift       = bitEnd;
                RX_PARITY: parity_load = bitEnd;
                RX_STOP:   check_stop  = bitEnd;
                default:   ;
            endcase
        end
    end

    rx_frame_status #(
        .PARITY_EN(PARITY_EN)
    ) u_status (
        .clk_i            (rx_clk),
        .rst_i            (rx_rst),
        .complete_i       (check_stop),
        .parityErr_i      (parErr_q),
        .stopErr_i        (~rx_in),
        .frameReady_i     (frame_ready),
        .overrunClr_i     (overrun_clr),
        .frameValid_o     (frame_valid),
        .frameParityErr_o (frame_parity_err),
        .frameStopErr_o   (frame_stop_err),
        .overrun_o        (overrun)
    );

endmodule

// File: tb/tb_rx_ctrl.sv
// Self-checking bench for rx_ctrl: drives whole serial frames tick by tick and
// predicts strobes and frame status from mid-bit sampling arithmetic.
module tb_rx_ctrl;
    import rx_ctrl_pkg::*;

    localparam int DW          = DEF_DATA_WIDTH;
    localparam int OS          = DEF_OVERSAMPLE;
    localparam bit PEN         = DEF_PARITY_EN;
    localparam int FRAME_BITS  = DW + 2 + (PEN ? 1 : 0);
    localparam int FRAME_TICKS = FRAME_BITS * OS;
    localparam int START_MID   = OS / 2;
    localparam int PARITY_MID  = START_MID + (DW + 1) * OS;
    localparam int STOP_MID    = START_MID + (FRAME_BITS - 1) * OS;

    logic rx_clk = 1'b0;
    logic rx_rst, sample_tick, rx_in, parity_bit_error, frame_ready, overrun_clr;
    logic shift, parity_load, check_stop, rx_busy, frame_valid;
    logic frame_parity_err, frame_stop_err, false_start, overrun;

    int vectors = 0;
    int miscompares = 0;

    bit mIdle = 1'b1;
    int phase = 0;
    bit mPendPar = 1'b0;
    bit mValid = 1'b0;
    bit mPar = 1'b0;
    bit mStop = 1'b0;
    bit mOvr = 1'b0;
    int shiftCount = 0;
    int fsCount = 0;

    rx_ctrl #(
        .DATA_WIDTH(DW),
        .OVERSAMPLE(OS),
        .PARITY_EN (PEN)
    ) dut (
        .rx_clk           (rx_clk),
        .rx_rst           (rx_rst),
        .sample_tick      (sample_tick),
        .rx_in            (rx_in),
        .parity_bit_error (parity_bit_error),
        .shift            (shift),
        .parity_load      (parity_load),
        .check_stop       (check_stop),
        .rx_busy          (rx_busy),
        .frame_valid      (frame_valid),
        .frame_ready      (frame_ready),
        .frame_parity_err (frame_parity_err),
        .frame_stop_err   (frame_stop_err),
        .false_start      (false_start),
        .overrun          (overrun),
        .overrun_clr      (overrun_clr)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput(input bit eShift, input bit ePar, input bit eStop, input bit eFalse);
        if (false_start === 1'b1) fsCount++;
        checkBit("shift", shift, eShift);
        checkBit("parity_load", parity_load, ePar);
        checkBit("check_stop", check_stop, eStop);
        checkBit("false_start", false_start, eFalse);
        if (!rx_rst) begin
            checkBit("rx_busy", rx_busy, !mIdle);
            checkBit("frame_valid", frame_valid, mValid);
            checkBit("overrun", overrun, mOvr);
            if (mValid) begin
                checkBit("frame_parity_err", frame_parity_err, mPar);
                checkBit("frame_stop_err", frame_stop_err, mStop);
            end
        end
    endtask

    // One rx_clk cycle: drive at negedge, check, advance the frame-level model.
    task automatic applyStimulus(input logic tickVal);
        bit eShift, ePar, eStop, eFalse, nextIdle, ovrSet;
        int nPhase;
        eShift = 0; ePar = 0; eStop = 0; eFalse = 0;
        @(negedge rx_clk);
        sample_tick = tickVal;
        #1;
        nextIdle = mIdle;
        nPhase = phase;
        if (!rx_rst && tickVal) begin
            if (mIdle) begin
                if (rx_in == 1'b0) begin
                    nextIdle = 0;
                    nPhase = 0;
                end
            end else begin
                nPhase = phase + 1;
                if (nPhase == START_MID && rx_in == 1'b1) begin
                    eFalse = 1;
                    nextIdle = 1;
                end else if (nPhase >= START_MID + OS && nPhase <= START_MID + DW * OS
                             && (nPhase - START_MID) % OS == 0) begin
                    eShift = 1;
                end else if (PEN && nPhase == PARITY_MID) begin
                    ePar = 1;
                end else if (nPhase == STOP_MID) begin
                    eStop = 1;
                    nextIdle = 1;
                end
            end
        end
        checkOutput(eShift, ePar, eStop, eFalse);
        if (eShift) shiftCount++;
        if (rx_rst) begin
            mIdle = 1; phase = 0; mPendPar = 0;
            mValid = 0; mPar = 0; mStop = 0; mOvr = 0;
        end else begin
            ovrSet = eStop && mValid && !frame_ready;
            if (ePar) mPendPar = parity_bit_error;
            if (eStop) begin
                mValid = 1;
                mPar = PEN ? mPendPar : 1'b0;
                mStop = !rx_in;
            end else if (mValid && frame_ready) begin
                mValid = 0;
            end
            if (ovrSet) mOvr = 1;
            else if (overrun_clr) mOvr = 0;
            mIdle = nextIdle;
            phase = nPhase;
        end
        @(posedge rx_clk);
        #1;
    endtask

    task automatic idleTicks(input int n, input int div);
        rx_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            repeat (div - 1) applyStimulus(1'b0);
            applyStimulus(1'b1);
        end
    endtask

    // Serial frame: start, data LSB first, optional parity, stop; one tick every div cycles.
    task automatic sendFrame(input logic [DW-1:0] data, input bit perr, input bit stopBit,
                             input int div, input bit readyAtStop, input bit clrAtStop,
                             input int abortTick);
        logic [FRAME_BITS-1:0] bits;
        logic savedReady;
        savedReady = frame_ready;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1 + i] = data[i];
        if (PEN) bits[DW + 1] = (^data) ^ perr;
        bits[FRAME_BITS - 1] = stopBit;
        shiftCount = 0;
        for (int k = 0; k < FRAME_TICKS; k++) begin
            rx_in = bits[k / OS];
            parity_bit_error = (PEN && (k / OS) == DW + 1) ? perr : 1'($urandom_range(0, 1));
            repeat (div - 1) applyStimulus(1'b0);
            if (k == abortTick) begin
                rx_rst = 1'b1;
                applyStimulus(1'b1);
                rx_rst = 1'b0;
                rx_in = 1'b1;
                return;
            end
            if (k == STOP_MID) begin
                frame_ready = readyAtStop;
                overrun_clr = clrAtStop;
            end
            applyStimulus(1'b1);
            if (k == STOP_MID) begin
                frame_ready = savedReady;
                overrun_clr = 1'b0;
            end
        end
        rx_in = 1'b1;
        checkInt("shift_count", shiftCount, DW);
    endtask

    task automatic sendGlitch(input int len, input int div);
        fsCount = 0;
        rx_in = 1'b0;
        for (int i = 0; i < len; i++) begin
            repeat (div - 1) applyStimulus(1'b0);
            applyStimulus(1'b1);
        end
        idleTicks(12, div);
        checkInt("false_start_count", fsCount, 1);
    endtask

    initial begin
        rx_rst = 1'b1;
        sample_tick = 1'b0;
        rx_in = 1'b1;
        parity_bit_error = 1'b0;
        frame_ready = 1'b0;
        overrun_clr = 1'b0;
        repeat (3) applyStimulus(1'b0);
        rx_rst = 1'b0;
        repeat (2) applyStimulus(1'b0);

        // Clean 0xA5 frame, then accept it.
        sendFrame(8'hA5, 1'b0, 1'b1, 4, 1'b0, 1'b0, -1);
        frame_ready = 1'b1;
        applyStimulus(1'b0);
        frame_ready = 1'b0;
        applyStimulus(1'b0);

        sendGlitch(5, 4);

        // Parity and framing error, then a clean frame clears them.
        sendFrame(8'h3C, 1'b1, 1'b0, 4, 1'b0, 1'b0, -1);
        idleTicks(2, 4);
        frame_ready = 1'b1;
        sendFrame(8'h5A, 1'b0, 1'b1, 4, 1'b1, 1'b0, -1);
        idleTicks(2, 4);
        frame_ready = 1'b0;

        // Overrun set, cleared alone, then clear coinciding with a set.
        sendFrame(8'h11, 1'b0, 1'b1, 2, 1'b0, 1'b0, -1);
        sendFrame(8'h22, 1'b1, 1'b1, 2, 1'b0, 1'b0, -1);
        applyStimulus(1'b0);
        overrun_clr = 1'b1;
        applyStimulus(1'b0);
        overrun_clr = 1'b0;
        applyStimulus(1'b0);
        sendFrame(8'h33, 1'b0, 1'b0, 2, 1'b0, 1'b1, -1);
        applyStimulus(1'b0);
        overrun_clr = 1'b1;
        frame_ready = 1'b1;
        applyStimulus(1'b0);
        overrun_clr = 1'b0;
        frame_ready = 1'b0;
        applyStimulus(1'b0);

        // Accept in the completion cycle of frame 2 is not an overrun.
        sendFrame(8'h44, 1'b0, 1'b1, 2, 1'b0, 1'b0, -1);
        sendFrame(8'h55, 1'b1, 1'b0, 2, 1'b1, 1'b0, -1);
        applyStimulus(1'b0);

        // Reset mid-DATA while a frame is still presented, then a full frame.
        sendFrame(8'h66, 1'b0, 1'b1, 4, 1'b0, 1'b0, START_MID + 3 * OS + 4);
        checkInt("shifts_before_reset", shiftCount, 3);
        applyStimulus(1'b0);
        sendFrame(8'h99, 1'b0, 1'b1, 4, 1'b0, 1'b0, -1);
        frame_ready = 1'b1;
        applyStimulus(1'b0);

        // Randomized frames, glitches and handshakes, including continuous ticks.
        for (int n = 0; n < 14; n++) begin
            int div;
            div = $urandom_range(1, 5);
            frame_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                sendGlitch($urandom_range(1, START_MID), div);
            end else begin
                sendFrame(DW'($urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0), div,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            end
            idleTicks($urandom_range(0, 3), div);
            overrun_clr = ($urandom_range(0, 2) == 0);
            applyStimulus(1'b0);
            overrun_clr = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_ctrl.md
Name: rx_ctrl

Overview:
Receive-side sequencer for the UART RX datapath. It tracks bit timing from an external oversampling tick, validates the start bit at mid-bit, and issues single-cycle shift / parity_load / check_stop strobes to the SIPO, parity checker and stop-bit logic. It latches per-frame status and presents a completed frame to the consumer over a valid/ready handshake with overrun detection. It sits between the RX front end (synchronised rx_in, tick generator) and the RX_DATA consumer.

Parameters:
DATA_WIDTH, `DATA_WIDTH (8), data bits per frame; must match sipo.
OVERSAMPLE, 16, sample ticks per bit; even, >=4.
PARITY_EN, 1, 1 = frame carries a parity bit after the data bits.

Ports:
rx_clk  input  1  RX clock; every register samples on its rising edge.
rx_rst  input  1  synchronous, active-high reset.
sample_tick  input  1  one-cycle pulse, OVERSAMPLE per bit time.
rx_in  input  1  serial line, already synchronised; idle high.
parity_bit_error  input  1  from parity_checker; valid in the parity_load cycle.
shift  output  1  SIPO shift enable, one cycle per data bit.
parity_load  output  1  parity checker strobe, one cycle.
check_stop  output  1  stop-bit check strobe, one cycle.
rx_busy  output  1  high in any state other than IDLE.
frame_valid  output  1  completed frame available.
frame_ready  input  1  consumer accepts the frame.
frame_parity_err  output  1  parity error of the presented frame.
frame_stop_err  output  1  stop-bit (framing) error of the presented frame.
false_start  output  1  one-cycle pulse when the start bit is rejected.
overrun  output  1  sticky; a frame completed while the previous one was unaccepted.
overrun_clr  input  1  clears overrun.

Behaviour:
- Reset: state IDLE, sample counter 0, bit index 0, all outputs 0. Reset mid-frame abandons the frame with no strobes and no status update.
- The counter and all strobes advance only in cycles where sample_tick=1. Each strobe is high for exactly that rx_clk cycle.
- IDLE: on a tick with rx_in=0, go to START with cnt<=0.
- START: each tick increments cnt. On the tick where cnt==OVERSAMPLE/2-1:
  - rx_in=1: pulse false_start, return to IDLE.
  - rx_in=0: cnt<=0, bit_idx<=0, go to DATA.
- DATA: each tick increments cnt. On the tick where cnt==OVERSAMPLE-1: assert shift, cnt<=0, bit_idx++. After the DATA_WIDTH-th shift, go to PARITY if PARITY_EN, else STOP.
- PARITY: on the tick where cnt==OVERSAMPLE-1, assert parity_load, capture parity_bit_error into a pending register, cnt<=0, go to STOP.
- STOP: on the tick where cnt==OVERSAMPLE-1:
  - assert check_stop;
  - pending stop error = ~rx_in;
  - go to IDLE. A new start is accepted from the next tick, since the mid stop bit counts as end of frame.
- Completion: the cycle after check_stop, frame_valid<=1 and frame_parity_err / frame_stop_err <= pending values (parity error forced 0 when PARITY_EN=0).
- Handshake:
  - Transfer occurs when frame_valid & frame_ready; frame_valid drops the next cycle unless a new completion coincides.
  - frame_ready while frame_valid=0 is ignored.
  - Status outputs hold stable while frame_valid=1 and no new completion occurs.
- Overrun:
  - Completion while frame_valid=1 and frame_ready=0 sets overrun. The new status overwrites the old, and frame_valid stays 1.
  - Completion in the same cycle as an accepting frame_ready is not an overrun.
  - overrun_clr clears overrun; a set event in the same cycle as overrun_clr wins.
- rx_busy is combinational from state. sample_tick held high continuously is legal (OVERSAMPLE=1-cycle bits at rx_clk rate).

Decomposition:
- uart_params.vh: DATA_WIDTH (existing), OVERSAMPLE default, PARITY_EN default, state encodings RX_IDLE/RX_START/RX_DATA/RX_PARITY/RX_STOP.
- One sub-module, rx_frame_status: the valid/ready holding register with error latches and overrun logic. The FSM and counters stay in rx_ctrl.

Test Plan:
- Frame 0xA5, parity correct, tick every 4 cycles -> 8 shift pulses exactly 16 ticks apart (first at 24 ticks after the falling-edge tick), one parity_load, one check_stop; frame_valid=1 one cycle after check_stop; both errors 0.
- Low glitch of 5 ticks on idle line -> false_start pulses once at tick 8; no shift; rx_busy returns 0; frame_valid stays 0.
- Stop bit sampled 0, and parity_bit_error=1 during parity_load -> frame_stop_err=1, frame_parity_err=1; next clean frame with frame_ready=1 -> both clear.
- Two back-to-back frames with frame_ready=0 -> overrun=1 after second check_stop+1, frame_valid stays 1. overrun_clr=1 alone -> 0. overrun_clr coincident with a third completion -> overrun stays 1.
- frame_ready asserted exactly in the completion cycle of frame 2 while frame 1 is valid -> overrun stays 0, frame_valid stays 1, and frame 2 status is presented.
- rx_rst asserted mid-DATA (after 3 shifts) -> next cycle IDLE, all outputs 0. Subsequent full frame received correctly with exactly 8 shifts.
